// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM read/write arbiter.
// Holds the default geometry of the SRAM macro, the write-mask lane width
// and the arbiter state encoding used when the post-reset zero sweep
// (SRAM_ARB_INIT_EN) is built in.
package sram_arb_pkg;

  localparam int unsigned DEF_DEPTH      = 32'd2;
  localparam int unsigned DEF_DATA_W     = 32'd82;
  localparam int unsigned DEF_MASK_W     = 32'd2;
  localparam int unsigned DEF_STARVE_MAX = 32'd3;
  localparam int unsigned LANE_W         = DEF_DATA_W / DEF_MASK_W;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sram_resp_hold.sv
// Read response path for the SRAM arbiter.
// Tracks the read issued last cycle (inflight), captures the SRAM output
// into a hold register when the consumer stalls, and selects what the
// consumer sees. slot_free tells the arbiter whether a new read may issue.
// Ports:
//   clock, reset    : clock, synchronous active-high reset
//   rd_grant        : a read is presented to the SRAM this cycle
//   resp_ready      : consumer accepts resp_data
//   sram_rdata      : SRAM output (valid the cycle after a read)
//   resp_valid      : response available
//   resp_data       : response word
//   slot_free       : a read granted now has somewhere to land
module sram_resp_hold #(
  parameter int unsigned DATA_W = 32'd82
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_grant,
  input  logic              resp_ready,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              slot_free
);

  logic              inflight;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;

  // Inflight flag and hold register; the SRAM output tracks later writes,
  // so a stalled response must be frozen the first cycle it is not taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight   <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      inflight <= rd_grant;
      if (inflight && !resp_ready) begin
        hold_valid <= 1'b1;
        hold_data  <= sram_rdata;
      end else if (hold_valid && resp_ready) begin
        hold_valid <= 1'b0;
      end else begin
        hold_valid <= hold_valid;
      end
    end
  end

  // inflight and hold_valid are never set together: a stalled inflight
  // response blocks new reads, so inflight drops as hold_valid rises.
  assign resp_valid = inflight | hold_valid;
  assign resp_data  = hold_valid ? hold_data : sram_rdata;
  assign slot_free  = !hold_valid && (!inflight || resp_ready);

endmodule

// File: rtl/sram_rw_arbiter.sv
// Arbiter sharing the single RW port of a masked single-port SRAM macro
// between one write requester and one read requester.
// Writes win by default; a read that has lost STARVE_MAX consecutive
// eligible cycles is forced through. Read data has 1-cycle latency and is
// held across consumer backpressure by sram_resp_hold.
// Optional macro SRAM_ARB_INIT_EN: after reset, sweep all addresses with
// zero (full mask) before accepting traffic; otherwise init_done is 1.
// Ports:
//   clock, reset                       : clock, synchronous active-high reset
//   w_valid/w_ready/w_addr/w_mask/w_data : write request channel
//   r_valid/r_ready/r_addr             : read request channel
//   resp_valid/resp_ready/resp_data    : read response channel
//   sram_en/sram_wmode/sram_addr/sram_wmask/sram_wdata/sram_rdata : SRAM pins
//   init_done                          : arbiter is accepting traffic
module sram_rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_W     = $clog2(DEPTH),
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MASK_W     = DEF_MASK_W,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [MASK_W-1:0] w_mask,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              init_done
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 32'd1);

  logic              run;
  logic              active;
  logic              init_wr;
  logic [ADDR_W-1:0] init_addr;
  logic              slot_free;
  logic              force_read;
  logic              read_wins;
  logic              wr_grant;
  logic              rd_grant;
  logic [CNT_W-1:0]  starve_cnt;

`ifdef SRAM_ARB_INIT_EN
  arb_state_e state;

  // INIT/RUN sequencer: one zero write per cycle from address 0 upward.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_INIT;
      init_addr <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_addr == ADDR_W'(DEPTH - 32'd1)) begin
            state     <= ST_RUN;
            init_addr <= '0;
          end else begin
            state     <= ST_INIT;
            init_addr <= init_addr + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          state     <= ST_RUN;
          init_addr <= '0;
        end
        default: begin
          state     <= ST_INIT;
          init_addr <= '0;
        end
      endcase
    end
  end

  assign run       = (state == ST_RUN);
  assign init_wr   = (state == ST_INIT) && !reset;
  assign init_done = run;
`else
  assign run       = 1'b1;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
  assign init_done = 1'b1;
`endif

  // Nothing is granted while reset is asserted so the SRAM is idle then.
  assign active     = run && !reset;
  assign force_read = (starve_cnt == CNT_W'(STARVE_MAX));
  assign read_wins  = active && r_valid && slot_free && (!w_valid || force_read);
  assign rd_grant   = read_wins;
  assign wr_grant   = active && w_valid && !read_wins;
  assign w_ready    = active && !read_wins;
  assign r_ready    = active && slot_free && (!w_valid || force_read);

  // Starvation counter: counts eligible reads that lost to a write.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!r_valid || rd_grant) begin
      starve_cnt <= '0;
    end else if (active && slot_free && !force_read) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  // SRAM pin drive: exactly one source per cycle, idle values otherwise.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (init_wr) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_addr;
      sram_wmask = '1;
      sram_wdata = '0;
    end else if (wr_grant) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = w_addr;
      sram_wmask = w_mask;
      sram_wdata = w_data;
    end else if (rd_grant) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b0;
      sram_addr  = r_addr;
    end else begin
      sram_en    = 1'b0;
      sram_wmode = 1'b0;
    end
  end

  sram_resp_hold #(
    .DATA_W (DATA_W)
  ) u_resp_hold (
    .clock      (clock),
    .reset      (reset),
    .rd_grant   (rd_grant),
    .resp_ready (resp_ready),
    .sram_rdata (sram_rdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .slot_free  (slot_free)
  );

endmodule
